// File: rtl/mem_access_unit.sv
// MEM-stage data-memory initiator: extends sub-word loads, does read-modify-write for sh/sb.
// Sub-word support (lh/lhu/lb/lbu/sh/sb and the RMW state) is built only with MEM_ACC_SUBWORD_EN.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_wr,
    input  logic [31:0]       mem_rdata
);
    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_SW  = 3'd5;
`ifdef MEM_ACC_SUBWORD_EN
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;
`endif

    logic        bad_align;
    logic        is_store;
    logic [31:0] load_ext;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        misalign_q, misalign_d;

    assign is_store = (req_op >= OP_SW);

    always_comb begin
        case (req_op)
            OP_LW, OP_SW: bad_align = (req_addr[1:0] != 2'b00);
`ifdef MEM_ACC_SUBWORD_EN
            OP_LH, OP_LHU, OP_SH: bad_align = req_addr[0];
            default: bad_align = 1'b0;
`else
            // Without sub-word support every other op is rejected like a misaligned access.
            default: bad_align = 1'b1;
`endif
        endcase
    end

`ifdef MEM_ACC_SUBWORD_EN
    typedef enum logic {IDLE, RMW} state_t;

    state_t            state_q, state_d;
    logic [31:0]       rmw_buf_q, rmw_buf_d;
    logic [ADDR_W-1:0] rmw_addr_q, rmw_addr_d;
    logic [4:0]        lane_sh;
    logic [15:0]       rd_lane;
    logic [31:0]       wmask;
    logic [31:0]       merged;

    assign lane_sh = {req_addr[1:0], 3'b000};
    assign rd_lane = 16'(mem_rdata >> lane_sh);
    assign wmask   = ((req_op == OP_SB) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_sh;
    assign merged  = (mem_rdata & ~wmask) | ((req_wdata << lane_sh) & wmask);

    always_comb begin
        case (req_op)
            OP_LH:   load_ext = {{16{rd_lane[15]}}, rd_lane};
            OP_LHU:  load_ext = {16'h0000, rd_lane};
            OP_LB:   load_ext = {{24{rd_lane[7]}}, rd_lane[7:0]};
            OP_LBU:  load_ext = {24'h000000, rd_lane[7:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        mem_addr     = req_addr;
        mem_wdata    = req_wdata;
        mem_wr       = 1'b0;
        stall        = 1'b0;
        state_d      = state_q;
        rmw_buf_d    = rmw_buf_q;
        rmw_addr_d   = rmw_addr_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        misalign_d   = 1'b0;
        if (state_q == RMW) begin
            mem_addr  = rmw_addr_q;
            mem_wdata = rmw_buf_q;
            mem_wr    = 1'b1;
            state_d   = IDLE;
        end else if (req_valid) begin
            if (bad_align) begin
                misalign_d = 1'b1;
            end else if (req_op == OP_SW) begin
                mem_wr = 1'b1;
            end else if (is_store) begin
                stall      = 1'b1;
                rmw_buf_d  = merged;
                rmw_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                state_d    = RMW;
            end else begin
                load_data_d  = load_ext;
                load_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rmw_buf_q  <= '0;
            rmw_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            rmw_buf_q  <= rmw_buf_d;
            rmw_addr_q <= rmw_addr_d;
        end
    end
`else
    assign load_ext = mem_rdata;

    always_comb begin
        mem_addr     = req_addr;
        mem_wdata    = req_wdata;
        mem_wr       = 1'b0;
        stall        = 1'b0;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        misalign_d   = 1'b0;
        if (req_valid) begin
            if (bad_align) begin
                misalign_d = 1'b1;
            end else if (is_store) begin
                mem_wr = 1'b1;
            end else begin
                load_data_d  = load_ext;
                load_valid_d = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            misalign_q   <= misalign_d;
        end
    end

    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign misalign   = misalign_q;
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator side of the data-memory port in the pipelined MIPS core. It sits in the MEM stage between the EX/MEM pipeline register and the word-addressed data memory. It turns load and store requests (lw/lh/lhu/lb/lbu/sw/sh/sb) into word reads and writes: sign/zero-extends load results, performs two-cycle read-modify-write for sub-word stores, and flags misaligned accesses. The data memory reads combinationally and writes on posedge clk when its write enable is high; this block drives that port.

## Interface
- ADDR_W, 32, width of request and memory address buses
- clk  in  1  system clock, all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  MEM stage holds a memory operation this cycle
- req_op  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data (sub-word stores use low byte/halfword)
- stall  out  1  hold upstream pipeline; request must stay stable while high
- load_data  out  32  registered, extended load result
- load_valid  out  1  one-cycle pulse, load_data valid
- misalign  out  1  one-cycle pulse, request rejected
- mem_addr  out  ADDR_W  address to data memory
- mem_wdata  out  32  write word to data memory
- mem_wr  out  1  write enable to data memory
- mem_rdata  in  32  combinational read word from data memory

## Operation
- Byte lanes little-endian: lane k = bits 8k+7:8k selected by addr[1:0]; halfword by addr[1].
- FSM states IDLE, RMW. Reset -> IDLE.
- IDLE, no req_valid: mem_addr = req_addr, mem_wr = 0, stall = 0.
- Misaligned: lw/sw with addr[1:0] != 0; lh/lhu/sh with addr[0] != 0. No write, no load_valid; misalign pulses next cycle; stays IDLE.
- Loads (IDLE): mem_addr = req_addr; lane extracted from mem_rdata, sign-extended (lh, lb) or zero-extended (lhu, lbu); registered into load_data with load_valid pulse.
- sw (IDLE): mem_wr = 1, mem_wdata = req_wdata; committed at that edge; stall = 0.
- sh/sb (IDLE): mem_wr = 0, read word at req_addr; merge new lane into it; capture merged word and word address in rmw_buf/rmw_addr; stall = 1; -> RMW.
- RMW: mem_addr = rmw_addr, mem_wdata = rmw_buf, mem_wr = 1, stall = 0; request inputs ignored; -> IDLE.
- load_data holds its last value between loads; it is not cleared by stores.

## Timing
- Reset values: load_data 0, load_valid 0, misalign 0, stall 0, mem_wr 0, state IDLE, rmw_buf 0.
- Load latency 1: request in cycle N, load_data/load_valid valid in N+1.
- sw: zero stall, written at end of cycle N.
- sh/sb: stall high in N, memory write at end of N+1; pipeline advances after N+1.
- misalign: pulse in N+1, mutually exclusive with load_valid.
- mem_wr is never high in IDLE except for an aligned sw.
- rst_n asserted during RMW: write abandoned, memory unchanged, IDLE immediately.
- A new request presented in the cycle after RMW is handled normally from IDLE.

## Configuration
- MEM_ACC_SUBWORD_EN defined: full op set as above.
- Not defined: only lw (000) and sw (101) are supported. All other ops pulse misalign with no memory write. RMW state and rmw_buf are removed, and stall is tied 0.

## Test plan
- Memory word 0x10 = 0x8899AABB; lb at 0x11 -> load_data 0xFFFFFFAA, load_valid in next cycle; lbu at 0x11 -> 0x000000AA.
- lh at 0x12 -> 0xFFFF8899; lhu at 0x12 -> 0x00008899.
- sb data 0x55 at 0x13 on word 0x8899AABB -> stall 1 for one cycle, mem_wr in the second cycle, word becomes 0x5599AABB; reads back unchanged elsewhere.
- sw 0x12345678 at 0x20 -> mem_wr in same cycle, stall 0, lw 0x20 next returns 0x12345678.
- lw at 0x22 and sh at 0x21 -> misalign pulse, no mem_wr, memory unchanged, no load_valid.
- sh at 0x30 with rst_n dropped during RMW cycle -> no write, all outputs at reset values; without MEM_ACC_SUBWORD_EN, lb at 0x10 -> misalign pulse.
